cordic_channel_scheduler: RTL and testbench
===========================================

# cordic_channel_scheduler

Time-multiplexes one shared CORDIC rotator among `NCH` independent NCO channels. Each channel keeps its own phase accumulator. The block round-robins between enabled channels and issues one rotation per service slot. It stores the returned sine/cosine into per-channel output registers. It sits between the per-channel frequency words (from the frequency-generator control path) and the single CORDIC instance, and replaces one-CORDIC-per-waveform instantiation.

## Interface
Parameters:
- `NCH`, 4: number of channels (2..16).
- `FREQ_W`, 16: per-channel frequency (phase increment) word width.
- `PHASE_W`, 32: phase accumulator and CORDIC angle width.
- `WAVE_W`, 16: sine/cosine sample width.
- `TIMEOUT`, 64: watchdog limit in cycles. Used only with the watchdog macro.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_in`, in, 1: synchronous, active-high reset.
- `enable`, in, 1: global run enable.
- `chan_en`, in, `NCH`: per-channel enable.
- `freq_in`, in, `NCH*FREQ_W`: channel i increment at `[i*FREQ_W +: FREQ_W]`.
- `cordic_start`, out, 1: one-cycle request to the CORDIC.
- `cordic_angle`, out, `PHASE_W`: angle; valid while `cordic_start`=1.
- `cordic_done`, in, 1: CORDIC result-valid pulse or level.
- `cordic_sin`, in, `WAVE_W`: CORDIC sine result.
- `cordic_cos`, in, `WAVE_W`: CORDIC cosine result.
- `wave_outsen`, out, `NCH*WAVE_W`: registered per-channel sine.
- `wave_outcos`, out, `NCH*WAVE_W`: registered per-channel cosine.
- `wave_valid`, out, `NCH`: one-cycle pulse on the channel just updated.
- `chan_sel`, out, `$clog2(NCH)`: channel currently in service.
- `busy`, out, 1: high in every state except IDLE.
- `timeout_err`, out, 1: sticky watchdog flag.

## Operation
- FSM states are IDLE, PICK, ISSUE, WAIT and STORE.
- **IDLE** goes to PICK when `enable` is high and `|chan_en` is true.
- **PICK** runs round-robin selection, searching upward from `last+1` and wrapping modulo `NCH`.
  - It selects the first channel with its `chan_en` bit high.
  - It latches that channel into `chan_sel`.
  - It goes to ISSUE.
  - If no channel is enabled by then, it goes back to IDLE.
- **ISSUE** asserts `cordic_start`=1 for exactly one cycle, with `cordic_angle` = `phase[chan_sel]`. It goes to WAIT.
- **WAIT** holds until it samples `cordic_done`=1, then goes to STORE. `cordic_done` is ignored in every other state.
- **STORE** performs four actions, all on the same clock edge:
  - Captures `cordic_sin`/`cordic_cos` into the selected channel's slot.
  - Pulses `wave_valid[chan_sel]`.
  - Updates `phase[chan_sel] += zero-extended freq_in[chan_sel]`, modulo 2^`PHASE_W` (wraps silently).
  - Sets `last` = `chan_sel`.
  
  It then goes to PICK if `enable` and `|chan_en` are both true, otherwise to IDLE.
- The CORDIC must hold `cordic_sin`/`cordic_cos` stable from `cordic_done` through the STORE cycle.
- When `chan_en` drops for the channel in flight, its transaction still completes and its results are stored. That channel is then skipped.
- When `enable` drops mid-transaction, the transaction completes and the FSM then goes to IDLE. Phases are retained.
- A channel whose `chan_en` bit is 0 keeps its phase and its last output sample.
- Reset: state = IDLE, all phases = 0, `last` = `NCH-1` (so the first grant goes to channel 0). All outputs are 0, including `timeout_err`.
- Reset asserted mid-operation aborts immediately. No store happens and no `wave_valid` is pulsed.

## Timing
- Service slot length is k+3 cycles: PICK, ISSUE, k WAIT cycles (including the cycle in which `cordic_done` is sampled), then STORE.
- Back-to-back slots add no IDLE cycle between them.
- `cordic_start` is asserted 2 cycles after IDLE sees the go condition.
- Channel outputs and `wave_valid` become visible in the cycle after STORE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Controlled by the macro `CORDIC_SCHED_WATCHDOG_EN`.
- **Defined:**
  - A WAIT-state counter is cleared on entry to WAIT.
  - When the count reaches `TIMEOUT` without `cordic_done`, the FSM goes to IDLE and sets `timeout_err`.
  - On a timeout, no store happens, no `wave_valid` is pulsed, the phase is not advanced and `last` is not updated, so the same channel is retried first.
  - `timeout_err` clears only on reset.
- **Undefined:** WAIT waits indefinitely and `timeout_err` is tied to 0.

## Structure
- Package `cordic_sched_pkg` holds:
  - the `sched_state_t` enum (IDLE, PICK, ISSUE, WAIT, STORE);
  - the default parameter constants;
  - the channel-index width helper.
- Sub-module `rr_arbiter`: combinational next-grant search taking the request vector and `last`, producing a grant index and a grant-valid flag. It is instantiated once and used in PICK.

## Test plan
- **Single channel:** `NCH`=4, `chan_en`=0001, `freq_in[0]`=0x1000, CORDIC model with done 4 cycles after start.
  - Angles issued are 0x0, 0x1000, 0x2000, …
  - Slot length is 7 cycles.
  - Only `wave_valid[0]` pulses.
- **Round-robin:** `chan_en`=1011.
  - Grant order is 0, 1, 3, 0, 1, 3.
  - Channel 2's outputs and phase stay at 0.
- **Phase wrap:** `freq_in[1]`=0xFFFF with `phase[1]` preset near 0xFFFF_FFFF via repeated slots.
  - The phase wraps modulo 2^32 with no error or stall.
- **Enable drop mid-WAIT:** deassert `enable` during WAIT.
  - The result is stored and `wave_valid` pulses once.
  - The FSM returns to IDLE and `busy`=0.
  - On re-enable, service resumes with the next channel in round-robin order.
- **Reset mid-WAIT:** assert `rst_in` during WAIT.
  - Next cycle all outputs and phases are 0 and the FSM is in IDLE.
  - A late `cordic_done` is ignored.
- **Watchdog (`CORDIC_SCHED_WATCHDOG_EN`, `TIMEOUT`=8):** CORDIC model never asserts done.
  - After 8 WAIT cycles `timeout_err`=1 and there is no `wave_valid`.
  - The same channel is re-issued with an unchanged angle.

Source files
------------

// File: rtl/cordic_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_sched_pkg
// Description : Shared types and constants for the CORDIC channel scheduler.
//               Holds the scheduler state encoding, the default parameter
//               values and the channel-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_sched_pkg;

    localparam int c_def_nch     = 4;
    localparam int c_def_freq_w  = 16;
    localparam int c_def_phase_w = 32;
    localparam int c_def_wave_w  = 16;
    localparam int c_def_timeout = 64;

    localparam int c_state_w = 3;

    typedef enum logic [c_state_w-1:0] {
        ST_IDLE  = 3'd0,
        ST_PICK  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STORE = 3'd4
    } sched_state_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int chan_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin next-grant search. Scans the
//               request vector upward from i_last+1, wrapping modulo NCH,
//               and returns the first requesting index.
// Ports       : i_req         - request vector, one bit per channel
//               i_last        - index of the most recently served channel
//               o_grant       - selected channel index
//               o_grant_valid - high when any request bit was found
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import cordic_sched_pkg::*;
#(
    parameter int NCH = c_def_nch
) (
    input  logic [NCH-1:0]         i_req,
    input  logic [$clog2(NCH)-1:0] i_last,
    output logic [$clog2(NCH)-1:0] o_grant,
    output logic                   o_grant_valid
);

    localparam int c_cw = chan_idx_w(NCH);

    always_comb begin
        int v_idx;
        o_grant       = '0;
        o_grant_valid = 1'b0;
        v_idx         = 0;
        // Offset 1..NCH so the channel just served is considered last.
        for (int i = 1; i <= NCH; i++) begin
            v_idx = (int'(i_last) + i) % NCH;
            if (!o_grant_valid && i_req[v_idx]) begin
                o_grant       = c_cw'(v_idx);
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : cordic_channel_scheduler
// Description : Shares one CORDIC rotator among NCH NCO channels. Each channel
//               owns a phase accumulator; enabled channels are served round
//               robin, one rotation per slot (PICK, ISSUE, WAIT.., STORE), and
//               the returned sin/cos land in per-channel output registers.
// Ports       : clk, rst_in            - clock, synchronous active-high reset
//               enable, chan_en        - global and per-channel run enables
//               freq_in                - packed per-channel phase increments
//               cordic_start/_angle    - one-cycle rotation request
//               cordic_done/_sin/_cos  - rotator result
//               wave_outsen/_outcos    - packed per-channel sample registers
//               wave_valid             - pulse on the channel just updated
//               chan_sel, busy         - channel in service, FSM not idle
//               timeout_err            - sticky watchdog flag
// Options     : CORDIC_SCHED_WATCHDOG_EN - bound WAIT to TIMEOUT cycles;
//               when undefined WAIT is unbounded and timeout_err is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_channel_scheduler
    import cordic_sched_pkg::*;
#(
    parameter int NCH     = c_def_nch,
    parameter int FREQ_W  = c_def_freq_w,
    parameter int PHASE_W = c_def_phase_w,
    parameter int WAVE_W  = c_def_wave_w,
    parameter int TIMEOUT = c_def_timeout
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    enable,
    input  logic [NCH-1:0]          chan_en,
    input  logic [NCH*FREQ_W-1:0]   freq_in,
    output logic                    cordic_start,
    output logic [PHASE_W-1:0]      cordic_angle,
    input  logic                    cordic_done,
    input  logic [WAVE_W-1:0]       cordic_sin,
    input  logic [WAVE_W-1:0]       cordic_cos,
    output logic [NCH*WAVE_W-1:0]   wave_outsen,
    output logic [NCH*WAVE_W-1:0]   wave_outcos,
    output logic [NCH-1:0]          wave_valid,
    output logic [$clog2(NCH)-1:0]  chan_sel,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int c_cw = chan_idx_w(NCH);

    sched_state_t        r_state;
    sched_state_t        w_state_next;
    logic [PHASE_W-1:0]  r_phase [NCH];
    logic [WAVE_W-1:0]   r_sin   [NCH];
    logic [WAVE_W-1:0]   r_cos   [NCH];
    logic [c_cw-1:0]     r_last;
    logic [c_cw-1:0]     r_chan_sel;
    logic [c_cw-1:0]     w_grant;
    logic                w_grant_valid;
    logic                w_go;
    logic                w_wd_expire;
    logic                r_start;
    logic                w_start_next;
    logic                r_busy;
    logic                w_busy_next;
    logic [PHASE_W-1:0]  r_angle;
    logic [NCH-1:0]      r_wave_valid;
    logic [FREQ_W-1:0]   w_freq_sel;

    assign w_go       = enable && (|chan_en);
    assign w_freq_sel = freq_in[r_chan_sel*FREQ_W +: FREQ_W];

    rr_arbiter #(
        .NCH(NCH)
    ) u_rr_arbiter (
        .i_req         (chan_en),
        .i_last        (r_last),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_go) w_state_next = ST_PICK;
            ST_PICK:  w_state_next = w_grant_valid ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (cordic_done) begin
                    w_state_next = ST_STORE;
                end else if (w_wd_expire) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_STORE: w_state_next = w_go ? ST_PICK : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Output decode, computed from the next state so the ports come
    // straight from flops.
    always_comb begin
        w_start_next = (w_state_next == ST_ISSUE);
        w_busy_next  = (w_state_next != ST_IDLE);
    end

    // Datapath: grant latch, per-channel phase and sample storage
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_angle      <= '0;
            r_chan_sel   <= '0;
            r_last       <= c_cw'(NCH - 1);
            r_wave_valid <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_phase[i] <= '0;
                r_sin[i]   <= '0;
                r_cos[i]   <= '0;
            end
        end else begin
            r_start      <= w_start_next;
            r_busy       <= w_busy_next;
            r_wave_valid <= '0;
            if (r_state == ST_PICK && w_grant_valid) begin
                r_chan_sel <= w_grant;
                r_angle    <= r_phase[w_grant];
            end
            if (r_state == ST_STORE) begin
                r_sin[r_chan_sel]        <= cordic_sin;
                r_cos[r_chan_sel]        <= cordic_cos;
                r_wave_valid[r_chan_sel] <= 1'b1;
                // Zero-extended increment; overflow wraps modulo 2^PHASE_W.
                r_phase[r_chan_sel]      <= r_phase[r_chan_sel] + PHASE_W'(w_freq_sel);
                r_last                   <= r_chan_sel;
            end
        end
    end

`ifdef CORDIC_SCHED_WATCHDOG_EN
    localparam int c_wd_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [c_wd_w-1:0] r_wd_cnt;
    logic              r_timeout_err;

    // Expire on the TIMEOUT-th WAIT cycle that still has no done.
    assign w_wd_expire = (r_state == ST_WAIT) && !cordic_done &&
                         (r_wd_cnt == c_wd_w'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_wd_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end
            if (w_wd_expire) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_wd_expire      = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_pack
            assign wave_outsen[g*WAVE_W +: WAVE_W] = r_sin[g];
            assign wave_outcos[g*WAVE_W +: WAVE_W] = r_cos[g];
        end
    endgenerate

    assign cordic_start = r_start;
    assign cordic_angle = r_angle;
    assign wave_valid   = r_wave_valid;
    assign chan_sel     = r_chan_sel;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cordic_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_channel_scheduler
// Description : Directed self-checking bench for cordic_channel_scheduler.
//               A small CORDIC stand-in returns sin = angle[19:4]^0x5A5A and
//               cos = angle[15:0]^0x1234 with done four cycles after start.
//               A 20-bit phase keeps the wrap-around reachable in few slots.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_channel_scheduler;

    localparam int NCH     = 4;
    localparam int FREQ_W  = 16;
    localparam int PHASE_W = 20;
    localparam int WAVE_W  = 16;
    localparam int TIMEOUT = 8;

    logic                  clk = 1'b0;
    logic                  rst_in;
    logic                  enable;
    logic [NCH-1:0]        chan_en;
    logic [NCH*FREQ_W-1:0] freq_in;
    logic                  cordic_start;
    logic [PHASE_W-1:0]    cordic_angle;
    logic                  cordic_done;
    logic [WAVE_W-1:0]     cordic_sin;
    logic [WAVE_W-1:0]     cordic_cos;
    logic [NCH*WAVE_W-1:0] wave_outsen;
    logic [NCH*WAVE_W-1:0] wave_outcos;
    logic [NCH-1:0]        wave_valid;
    logic [1:0]            chan_sel;
    logic                  busy;
    logic                  timeout_err;

    int n_total = 0;
    int n_bad   = 0;

    int          m_cnt   = 0;
    logic        m_never = 1'b0;
    logic [15:0] m_sin   = '0;
    logic [15:0] m_cos   = '0;

    logic [NCH-1:0] v_or;
    int             v_cnt;

    int          rr_ch  [5] = '{1, 3, 0, 1, 3};
    logic [19:0] rr_ang [5] = '{20'h00000, 20'h00000, 20'h03000, 20'h00100, 20'h00003};

    always #5 clk = ~clk;

    cordic_channel_scheduler #(
        .NCH     (NCH),
        .FREQ_W  (FREQ_W),
        .PHASE_W (PHASE_W),
        .WAVE_W  (WAVE_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .enable       (enable),
        .chan_en      (chan_en),
        .freq_in      (freq_in),
        .cordic_start (cordic_start),
        .cordic_angle (cordic_angle),
        .cordic_done  (cordic_done),
        .cordic_sin   (cordic_sin),
        .cordic_cos   (cordic_cos),
        .wave_outsen  (wave_outsen),
        .wave_outcos  (wave_outcos),
        .wave_valid   (wave_valid),
        .chan_sel     (chan_sel),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    // CORDIC stand-in: results held from start until the next start.
    always @(posedge clk) begin
        if (cordic_start) begin
            m_cnt <= 1;
            m_sin <= cordic_angle[19:4] ^ 16'h5A5A;
            m_cos <= cordic_angle[15:0] ^ 16'h1234;
        end else if (m_cnt != 0 && m_cnt < 1000) begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign cordic_done = (m_cnt == 4) && !m_never;
    assign cordic_sin  = m_sin;
    assign cordic_cos  = m_cos;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cordic_start, counting cycles and wave_valid pulses.
    task automatic next_start(output int cyc);
        cyc   = -1;
        v_or  = '0;
        v_cnt = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (wave_valid != '0) begin
                v_or = v_or | wave_valid;
                v_cnt++;
            end
            if (cordic_start) begin
                cyc = i;
                break;
            end
        end
        chk("start_seen", cordic_start, 1);
    endtask

    initial begin
        int          cyc;
        int          st_cnt;
        logic        all7;
        logic [19:0] exp_ang;

        rst_in  = 1'b1;
        enable  = 1'b0;
        chan_en = '0;
        freq_in = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy",   busy, 0);
        chk("rst_start",  cordic_start, 0);
        chk("rst_angle",  cordic_angle, 0);
        chk("rst_valid",  wave_valid, 0);
        chk("rst_sin",    wave_outsen, 0);
        chk("rst_cos",    wave_outcos, 0);
        chk("rst_sel",    chan_sel, 0);
        chk("rst_tmo",    timeout_err, 0);

        // Single channel
        rst_in          = 1'b0;
        chan_en         = 4'b0001;
        freq_in[15:0]   = 16'h1000;
        enable          = 1'b1;
        @(negedge clk);
        chk("pick_no_start", cordic_start, 0);
        chk("pick_busy", busy, 1);
        @(negedge clk);
        chk("start_2cyc", cordic_start, 1);
        chk("angle_0", cordic_angle, 20'h00000);
        chk("sel_0", chan_sel, 0);
        @(negedge clk);
        chk("start_one_cycle", cordic_start, 0);
        next_start(cyc);
        chk("slot_len", cyc + 1, 7);
        chk("angle_1000", cordic_angle, 20'h01000);
        chk("valid_only_ch0", v_or, 4'b0001);
        chk("valid_once", v_cnt, 1);
        chk("sin_ch0_a0", wave_outsen[15:0], 16'h5A5A);
        chk("cos_ch0_a0", wave_outcos[15:0], 16'h1234);
        chk("others_zero", wave_outsen[63:16], 64'd0);
        next_start(cyc);
        chk("slot_len2", cyc, 7);
        chk("angle_2000", cordic_angle, 20'h02000);
        chk("sin_ch0_a1", wave_outsen[15:0], 16'h5B5A);
        chk("cos_ch0_a1", wave_outcos[15:0], 16'h0234);

        // Round-robin over 1011
        chan_en        = 4'b1011;
        freq_in[31:16] = 16'h0100;
        freq_in[47:32] = 16'h7777;
        freq_in[63:48] = 16'h0003;
        for (int k = 0; k < 5; k++) begin
            next_start(cyc);
            chk($sformatf("rr_sel%0d", k), chan_sel, rr_ch[k]);
            chk($sformatf("rr_ang%0d", k), cordic_angle, rr_ang[k]);
        end
        chk("ch2_sin_idle", wave_outsen[47:32], 16'h0000);
        chk("ch2_cos_idle", wave_outcos[47:32], 16'h0000);
        chk("ch1_sin", wave_outsen[31:16], 16'h5A4A);

        // Phase wrap on channel 1 (phase[1] = 0x200, increment 0xFFFF)
        chan_en        = 4'b0010;
        freq_in[31:16] = 16'hFFFF;
        exp_ang        = 20'h00200;
        all7           = 1'b1;
        for (int k = 0; k < 17; k++) begin
            next_start(cyc);
            if (cyc != 7) all7 = 1'b0;
            chk($sformatf("wrap_ang%0d", k), cordic_angle, exp_ang);
            exp_ang = exp_ang + 20'h0FFFF;
        end
        chk("wrap_final", cordic_angle, 20'h001F0);
        chk("wrap_slots_7", all7, 1);
        chk("wrap_no_err", timeout_err, 0);

        // Enable drop mid-WAIT on channel 3
        chan_en = 4'b1011;
        next_start(cyc);
        chk("ed_sel", chan_sel, 3);
        chk("ed_ang", cordic_angle, 20'h00006);
        @(negedge clk);
        enable = 1'b0;
        v_or   = '0;
        v_cnt  = 0;
        st_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (wave_valid != '0) begin
                v_or = v_or | wave_valid;
                v_cnt++;
            end
            if (cordic_start) st_cnt++;
        end
        chk("ed_valid_once", v_cnt, 1);
        chk("ed_valid_ch3", v_or, 4'b1000);
        chk("ed_no_start", st_cnt, 0);
        chk("ed_idle", busy, 0);
        chk("ed_sin_ch3", wave_outsen[63:48], 16'h5A5A);
        chk("ed_cos_ch3", wave_outcos[63:48], 16'h1232);
        enable = 1'b1;
        next_start(cyc);
        chk("resume_sel", chan_sel, 0);
        chk("resume_ang", cordic_angle, 20'h04000);
        chan_en = 4'b0100;
        next_start(cyc);
        chk("ch2_sel", chan_sel, 2);
        chk("ch2_phase_kept", cordic_angle, 20'h00000);

        // Reset mid-WAIT
        @(negedge clk);
        rst_in = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk("mrst_busy",  busy, 0);
        chk("mrst_start", cordic_start, 0);
        chk("mrst_angle", cordic_angle, 0);
        chk("mrst_valid", wave_valid, 0);
        chk("mrst_sin",   wave_outsen, 0);
        chk("mrst_cos",   wave_outcos, 0);
        chk("mrst_sel",   chan_sel, 0);
        rst_in  = 1'b0;
        chan_en = 4'b0001;
        v_cnt   = 0;
        st_cnt  = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (wave_valid != '0) v_cnt++;
            if (busy) st_cnt++;
        end
        chk("late_done_no_valid", v_cnt, 0);
        chk("late_done_idle", st_cnt, 0);
        enable = 1'b1;
        next_start(cyc);
        chk("post_rst_lat", cyc, 2);
        chk("post_rst_sel", chan_sel, 0);
        chk("post_rst_ang", cordic_angle, 20'h00000);

`ifdef CORDIC_SCHED_WATCHDOG_EN
        // Watchdog: done never arrives for this slot
        m_never = 1'b1;
        v_cnt   = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (wave_valid != '0) v_cnt++;
        end
        chk("wd_not_yet", timeout_err, 0);
        @(negedge clk);
        if (wave_valid != '0) v_cnt++;
        chk("wd_flag", timeout_err, 1);
        chk("wd_idle", busy, 0);
        chk("wd_no_valid", v_cnt, 0);
        next_start(cyc);
        chk("wd_retry_lat", cyc, 2);
        chk("wd_retry_sel", chan_sel, 0);
        chk("wd_retry_ang", cordic_angle, 20'h00000);
        chk("wd_sticky", timeout_err, 1);
        m_never = 1'b0;
`else
        chk("tmo_tied_zero", timeout_err, 0);
`endif

        enable = 1'b0;
        repeat (12) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
